// File: rtl/sparc_ram_ctrl_if.sv
// Request/response bundle between a SPARC-style load/store master and the
// byte-addressed RAM controller.
interface sparc_ram_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              MFA;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] address;
  logic [63:0]       DataIn;
  logic [63:0]       DataOut;
  logic              MFC;
  logic              MAE;
  logic              Busy;

  modport master (
    output MFA, opcode, address, DataIn,
    input  DataOut, MFC, MAE, Busy
  );

  modport slave (
    input  MFA, opcode, address, DataIn,
    output DataOut, MFC, MAE, Busy
  );
endinterface

// File: rtl/sparc_ram_ctrl.sv
// Byte-addressed big-endian RAM with a SPARC-style MFA/MFC handshake.
// A request is captured in IDLE, waits LATENCY edges, performs the access on
// the WAIT->DONE edge and holds MFC until the master drops MFA.
module sparc_ram_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sparc_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STD  = 6'b000111;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       din_q;
  logic [63:0]       dout;
  logic              mfc;
  logic              mae;

  // Contents are deliberately not reset.
  logic [7:0] mem [DEPTH];

  logic [3:0]  size;      // access width in bytes, 0 = undefined opcode
  logic        is_load;
  logic        is_signed;
  logic        misaligned;
  logic        ok;
  logic        fire;
  logic        do_wr;
  logic [7:0]  rb [8];    // bytes at addr_q .. addr_q+7
  logic [63:0] ld_val;
  logic [63:0] wj;        // store data left-justified: byte i sits at [63-8i -: 8]

  // Decode the captured opcode into width / direction / signedness.
  always_comb begin
    size      = 4'd0;
    is_load   = 1'b0;
    is_signed = 1'b0;
    case (op_q)
      OP_LDSB: begin size = 4'd1; is_load = 1'b1; is_signed = 1'b1; end
      OP_LDSH: begin size = 4'd2; is_load = 1'b1; is_signed = 1'b1; end
      OP_LD:   begin size = 4'd4; is_load = 1'b1; end
      OP_LDUB: begin size = 4'd1; is_load = 1'b1; end
      OP_LDUH: begin size = 4'd2; is_load = 1'b1; end
      OP_LDD:  begin size = 4'd8; is_load = 1'b1; end
      OP_STB:  size = 4'd1;
      OP_STH:  size = 4'd2;
      OP_ST:   size = 4'd4;
      OP_STD:  size = 4'd8;
      default: size = 4'd0;
    endcase
  end

  // Natural alignment check; undefined opcodes are never flagged.
  always_comb begin
    case (size)
      4'd2:    misaligned = addr_q[0];
      4'd4:    misaligned = |addr_q[1:0];
      4'd8:    misaligned = |addr_q[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign ok    = (size != 4'd0) && !misaligned;
  assign fire  = (state == WAIT) && (cnt == 4'd0);
  assign do_wr = fire && ok && !is_load;

  // Gather the 8 bytes starting at the captured address (big-endian order).
  always_comb begin
    for (int i = 0; i < 8; i++) rb[i] = mem[addr_q + ADDR_W'(i)];
  end

  // Shape the load result; non-double loads leave DataOut[63:32] zero.
  always_comb begin
    case (size)
      4'd1:    ld_val = {32'b0, {24{is_signed & rb[0][7]}}, rb[0]};
      4'd2:    ld_val = {32'b0, {16{is_signed & rb[0][7]}}, rb[0], rb[1]};
      4'd4:    ld_val = {32'b0, rb[0], rb[1], rb[2], rb[3]};
      4'd8:    ld_val = {rb[0], rb[1], rb[2], rb[3], rb[4], rb[5], rb[6], rb[7]};
      default: ld_val = 64'b0;
    endcase
  end

  // Left-justify store data so the MSB of the operand lands at the lowest address.
  always_comb begin
    case (size)
      4'd1:    wj = {din_q[7:0],  56'b0};
      4'd2:    wj = {din_q[15:0], 48'b0};
      4'd4:    wj = {din_q[31:0], 32'b0};
      default: wj = din_q;
    endcase
  end

  // Memory writes happen only on the WAIT->DONE edge of a good store.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < size) mem[addr_q + ADDR_W'(i)] <= wj[8*(7-i) +: 8];
      end
    end
  end

  // Handshake FSM with registered MFC/MAE/DataOut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_q   <= 6'd0;
      addr_q <= '0;
      din_q  <= 64'd0;
      dout   <= 64'd0;
      mfc    <= 1'b0;
      mae    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MFA) begin
            op_q   <= bus.opcode;
            addr_q <= bus.address;
            din_q  <= bus.DataIn;
            cnt    <= 4'(LATENCY - 1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            mfc   <= 1'b1;
            mae   <= misaligned;
            if (ok && is_load) dout <= ld_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // A still-high MFA is the same request; wait for it to drop.
          if (!bus.MFA) begin
            state <= IDLE;
            mfc   <= 1'b0;
            mae   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.DataOut = dout;
  assign bus.MFC     = mfc;
  assign bus.MAE     = mae;
  assign bus.Busy    = (state != IDLE);

endmodule

// File: tb/tb_sparc_ram_ctrl.sv
// Randomized scoreboard bench for sparc_ram_ctrl. Three instances (LATENCY 2,
// 1 and 15) share the stimulus; only the selected one sees MFA.
module tb_sparc_ram_ctrl;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  localparam logic [5:0] LDSB = 6'b001001, LDSH = 6'b001010, LD  = 6'b001000;
  localparam logic [5:0] LDUB = 6'b000001, LDUH = 6'b000010, LDD = 6'b000011;
  localparam logic [5:0] STB  = 6'b000101, STH  = 6'b000110, ST  = 6'b000100;
  localparam logic [5:0] STD  = 6'b000111, UNDEF = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          mfa = 1'b0;
  logic [5:0]    opc = '0;
  logic [AW-1:0] adr = '0;
  logic [63:0]   din = '0;
  int            sel = 0;

  sparc_ram_ctrl_if #(.ADDR_W(AW)) b0 ();
  sparc_ram_ctrl_if #(.ADDR_W(AW)) b1 ();
  sparc_ram_ctrl_if #(.ADDR_W(AW)) b2 ();

  assign b0.MFA = mfa && (sel == 0);
  assign b1.MFA = mfa && (sel == 1);
  assign b2.MFA = mfa && (sel == 2);
  assign b0.opcode = opc;  assign b1.opcode = opc;  assign b2.opcode = opc;
  assign b0.address = adr; assign b1.address = adr; assign b2.address = adr;
  assign b0.DataIn = din;  assign b1.DataIn = din;  assign b2.DataIn = din;

  sparc_ram_ctrl #(.ADDR_W(AW), .LATENCY(2))  u_l2  (.clk(clk), .rst_n(rst_n), .bus(b0));
  sparc_ram_ctrl #(.ADDR_W(AW), .LATENCY(1))  u_l1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  sparc_ram_ctrl #(.ADDR_W(AW), .LATENCY(15)) u_l15 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic [63:0] dout;
  logic        mfc, mae, busy;
  always_comb begin
    case (sel)
      1:       begin dout = b1.DataOut; mfc = b1.MFC; mae = b1.MAE; busy = b1.Busy; end
      2:       begin dout = b2.DataOut; mfc = b2.MFC; mae = b2.MAE; busy = b2.Busy; end
      default: begin dout = b0.DataOut; mfc = b0.MFC; mae = b0.MAE; busy = b0.Busy; end
    endcase
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] dout;
    logic        mae;
    int          cap;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mm [DEPTH];
  logic [63:0] mdout = '0;

  function automatic int lat_of(input int s);
    return (s == 1) ? 1 : (s == 2) ? 15 : 2;
  endfunction

  function automatic int op_size(input logic [5:0] op);
    case (op)
      LDSB, LDUB, STB: return 1;
      LDSH, LDUH, STH: return 2;
      LD, ST:          return 4;
      LDD, STD:        return 8;
      default:         return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [5:0] op);
    return op inside {LDSB, LDSH, LD, LDUB, LDUH, LDD};
  endfunction

  // Apply one request to the model and queue the response it must produce.
  task automatic model(input logic [5:0] op, input logic [AW-1:0] a, input logic [63:0] d);
    exp_t        e;
    int          n;
    logic [63:0] v;
    n = op_size(op);
    e.mae = (n > 1) && ((int'(a) % n) != 0);
    if (n != 0 && !e.mae) begin
      if (op_load(op)) begin
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(mm[int'(a) + i]);
        if ((op == LDSB || op == LDSH) && v[8*n-1])
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        mdout = v;
      end else begin
        for (int i = 0; i < n; i++) mm[int'(a) + i] = 8'(d >> (8*(n-1-i)));
      end
    end
    e.dout = mdout;
    e.cap  = cyc + 1;
    e.lat  = lat_of(sel);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic mfc_q = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mfc && !mfc_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected MFC", 64'(mfc), 64'(mfc_q));
        end else begin
          e = exp_q.pop_front();
          check("DataOut", dout, e.dout);
          check("MAE", 64'(mae), 64'(e.mae));
          check("MFC latency", 64'(cyc - e.cap), 64'(e.lat));
          check("Busy in DONE", 64'(busy), 64'd1);
        end
      end
      mfc_q = mfc;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [5:0] op, input logic [AW-1:0] a, input logic [63:0] d,
                       input bit pulse);
    bit seen;
    @(negedge clk);
    model(op, a, d);
    opc = op; adr = a; din = d; mfa = 1'b1;
    @(negedge clk);
    // Request is captured; later input changes must not matter.
    if (pulse) mfa = 1'b0;
    opc = 6'($urandom); adr = AW'($urandom); din = {$urandom, $urandom};
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (mfc) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      check("MFC timeout", 64'(mfc), 64'd1);
      mfa = 1'b0;
      return;
    end
    if (!pulse) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("MFC held while MFA high", 64'(mfc), 64'd1);
      end
      mfa = 1'b0;
    end
    @(negedge clk);
    check("MFC/MAE/Busy drop", {61'b0, mfc, mae, busy}, 64'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_req();
    logic [5:0]    ops [12] = '{LDSB, LDSH, LD, LDUB, LDUH, LDD, STB, STH, ST, STD, UNDEF, 6'b001011};
    logic [5:0]    op;
    logic [AW-1:0] a;
    int            n;
    op = ops[$urandom_range(0, 11)];
    n  = op_size(op);
    a  = AW'($urandom);
    if (n > 1 && ($urandom_range(0, 3) != 0)) a = a & ~AW'(n - 1);
    issue(op, a, {$urandom, $urandom}, ($urandom_range(0, 4) == 0));
  endtask

  // Fill memory, run the basic st/ld pair, then random traffic.
  task automatic run_phase(input int s, input int nrand);
    sel   = s;
    mdout = '0;
    for (int a = 0; a < DEPTH; a += 8) issue(STD, AW'(a), {$urandom, $urandom}, 1'b0);
    issue(ST, 9'h010, 64'h0000_0000_DEAD_BEEF, 1'b0);
    issue(LD, 9'h010, 64'h0, 1'b0);
    check("ld 0x010", dout, 64'h0000_0000_DEAD_BEEF);
    repeat (nrand) rand_req();
    drain();
  endtask

  initial begin
    sel = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset DataOut", dout, 64'd0);
    check("reset MFC/MAE/Busy", {61'b0, mfc, mae, busy}, 64'd0);
    rst_n = 1'b1;

    run_phase(0, 150);

    // Byte / half sign and zero extension.
    issue(STB,  9'h021, 64'h0000_0000_0000_0080, 1'b0);
    issue(LDSB, 9'h021, 64'h0, 1'b0);
    check("ldsb", dout, 64'h0000_0000_FFFF_FF80);
    issue(LDUB, 9'h021, 64'h0, 1'b0);
    check("ldub", dout, 64'h0000_0000_0000_0080);
    issue(STH,  9'h022, 64'h0000_0000_0000_8001, 1'b0);
    issue(LDSH, 9'h022, 64'h0, 1'b0);
    check("ldsh", dout, 64'h0000_0000_FFFF_8001);

    // Double at the top of memory.
    issue(STD, 9'h1F8, 64'h0123_4567_89AB_CDEF, 1'b0);
    issue(LDD, 9'h1F8, 64'h0, 1'b0);
    check("ldd top", dout, 64'h0123_4567_89AB_CDEF);
    issue(LD,  9'h1FC, 64'h0, 1'b0);
    check("ld 0x1FC", dout, 64'h0000_0000_89AB_CDEF);

    // Misaligned accesses and an undefined opcode leave state alone.
    issue(LD,  9'h013, 64'h0, 1'b0);
    check("misaligned ld keeps DataOut", dout, 64'h0000_0000_89AB_CDEF);
    issue(STD, 9'h004, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(LDD, 9'h000, 64'h0, 1'b0);
    issue(UNDEF, 9'h011, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    issue(LDD, 9'h010, 64'h0, 1'b0);

    // Single-cycle MFA pulse.
    issue(LD, 9'h1FC, 64'h0, 1'b1);
    check("pulse ld", dout, 64'h0000_0000_89AB_CDEF);

    // Reset in the middle of WAIT aborts the store.
    @(negedge clk);
    opc = ST; adr = 9'h040; din = 64'h0000_0000_5555_AAAA; mfa = 1'b1;
    @(negedge clk);
    check("Busy in WAIT", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-WAIT reset outputs", {dout[60:0], mfc, mae, busy}, 64'd0);
    mfa   = 1'b0;
    mdout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(LD, 9'h040, 64'h0, 1'b0);
    drain();

    run_phase(1, 40);
    run_phase(2, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sparc_ram_ctrl.md
SPARC_RAM_CTRL -- requirements
Module: sparc_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning byte-address width; depth = 2**ADDR_W bytes; legal range 3..16.
REQ-002 SHALL have parameter LATENCY, default 2, meaning clock edges from request capture to MFC rise; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port MFA  input  1  memory-function-activate; request, held high until MFC is seen.
REQ-006 SHALL have port opcode  input  6  access type (encodings in REQ-012).
REQ-007 SHALL have port address  input  ADDR_W  byte address, big-endian (lowest address = most significant byte).
REQ-008 SHALL have port DataIn  input  64  store data; byte/half/word stores use the low bits; std uses all 64 bits.
REQ-009 SHALL have port DataOut  output  64  load result; low 32 bits for non-double loads, upper 32 zero.
REQ-010 SHALL have port MFC  output  1  memory-function-complete acknowledge.
REQ-011 SHALL have ports MAE  output  1  misaligned-address error, qualified by MFC; and Busy  output  1  high when state is not IDLE.

Function
REQ-012 SHALL decode opcodes: 001001 ldsb, 001010 ldsh, 001000 ld, 000001 ldub, 000010 lduh, 000011 ldd, 000101 stb, 000110 sth, 000100 st, 000111 std.
REQ-013 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE.
- IDLE: MFA high at edge N -> capture opcode, address, DataIn; load counter with LATENCY-1; go WAIT.
- WAIT: decrement counter each edge; at the edge where counter == 0, perform the access, go DONE.
- DONE: MFC = 1; go IDLE at the first edge with MFA low.
REQ-014 SHALL raise MFC after edge N+LATENCY; MFC falls after the first edge with MFA low in DONE.
REQ-015 SHALL ignore input changes after capture; opcode, address and DataIn are used only from the capture registers.
REQ-016 SHALL sign-extend ldsb/ldsh from bit 7/15 of the loaded value and zero-extend ldub/lduh.
REQ-017 ld SHALL return bytes [a..a+3] big-endian; ldd SHALL return bytes [a..a+7] as DataOut[63:0].
REQ-018 stb/sth/st/std SHALL write 1/2/4/8 bytes from DataIn[7:0]/[15:0]/[31:0]/[63:0] big-endian.
REQ-019 SHALL check alignment: half needs address[0]=0; word needs address[1:0]=0; double needs address[2:0]=0.
- On violation: no memory write, DataOut unchanged, MAE=1 while MFC=1.
REQ-020 SHALL treat an undefined opcode as a no-op: MFC still asserted, MAE=0, DataOut and memory unchanged.
REQ-021 SHALL perform all memory writes at the WAIT->DONE edge and nowhere else.
REQ-022 SHALL update DataOut only on a successful load at that edge and hold it until the next successful load.
REQ-023 SHALL complete a request even if MFA drops during WAIT: DONE is entered, MFC is high for exactly one cycle, then IDLE.
REQ-024 SHALL treat MFA re-raised before DONE as the same request; a new request requires one IDLE edge with MFA high.
REQ-025 SHALL have no wrap-around: aligned accesses never cross the top of memory because ADDR_W >= 3.
REQ-026 SHALL deassert MAE and MFC in the same cycle.
REQ-027 SHALL assert Busy in WAIT and DONE and deassert it in IDLE.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, MFC=0, MAE=0, Busy=0, DataOut=0.
REQ-029 Memory contents SHALL NOT be reset; they are undefined after power-up.
REQ-030 Reset during WAIT SHALL abort the request with no memory write.
REQ-031 After rst_n rises, the first request SHALL be accepted at the first edge with MFA high.

Verification
REQ-032 With LATENCY=2: st 0xDEADBEEF at address 0x010, then ld 0x010 -> DataOut=0x00000000DEADBEEF; MFC rises 2 edges after capture in both accesses.
REQ-033 stb 0x80 at address 0x021; ldsb -> 0xFFFFFF80; ldub -> 0x00000080; sth 0x8001 at address 0x022 then ldsh -> 0xFFFF8001.
REQ-034 std 0x0123456789ABCDEF at address 0x1F8; ldd -> the same value; ld 0x1FC -> 0x89ABCDEF.
REQ-035 ld at address 0x013 -> MFC=1 and MAE=1, DataOut unchanged; std at address 0x004 -> MAE=1, and a subsequent ldd at address 0x000 shows unchanged memory.
REQ-036 MFA pulsed for one cycle -> MFC high exactly one cycle; rst_n low during WAIT of st at address 0x040 -> outputs zero immediately, and a later ld 0x040 shows the old contents.
REQ-037 Repeat REQ-032 with LATENCY=1 and with LATENCY=15 -> MFC timing matches REQ-014 exactly.
